// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction-fetch front end. Owns the PC, issues word requests to
// instruction memory, buffers the returned words in a small in-order FIFO and
// presents the head to the control unit. A taken branch on the consumed
// instruction (PCsrc) redirects fetch to instr_pc + ImmOp.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   imem_req/addr     fetch request and its word-aligned address
//   imem_gnt          memory accepts the request this cycle
//   imem_rvalid/rdata in-order read response
//   instr_valid       buffer head holds an instruction
//   instr, instr_pc   head instruction (addi x0,x0,0 when empty) and its address
//   instr_ready       decode consumes the head this cycle
//   PCsrc, ImmOp      branch taken / byte offset for the consumed instruction
//   fetch_err         sticky misaligned-redirect flag
//
// Optional feature macro: FETCH_ALIGN_CHK_EN
//   defined   : a misaligned redirect target sets fetch_err and halts fetch
//   undefined : fetch_err is 0 and target bits [1:0] are cleared
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    output logic                  fetch_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1) + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    // Address of the next response that will be kept; responses return in
    // order, so this is enough to tag each pushed word with its PC.
    logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         discard_q, discard_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;

    logic [DATA_WIDTH-1:0] buf_instr [DEPTH];
    logic [DATA_WIDTH-1:0] buf_pc    [DEPTH];

    logic                  grant, rsp, keep, drop, pop, redirect, push_en, halt;
    logic [DATA_WIDTH-1:0] target_raw, target;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef FETCH_ALIGN_CHK_EN
    logic err_q, err_d;
    assign halt      = err_q;
    assign fetch_err = err_q;
    assign target    = target_raw;
`else
    assign halt      = 1'b0;
    assign fetch_err = 1'b0;
    assign target    = target_raw & ~DATA_WIDTH'(3);
`endif

    // Requests are limited so every outstanding response already owns a slot.
    assign imem_req    = !rst && !halt && ((count_q + inflight_q) < DEPTH_C);
    assign imem_addr   = pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? buf_instr[rd_ptr_q] : NOP;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr_q] : '0;
    assign target_raw  = instr_pc + ImmOp;

    always_comb begin
        grant    = imem_req && imem_gnt;
        // A response with nothing outstanding belongs to a pre-reset request.
        rsp      = imem_rvalid && (inflight_q != '0);
        keep     = rsp && (discard_q == '0);
        drop     = rsp && (discard_q != '0);
        pop      = instr_valid && instr_ready;
        redirect = pop && PCsrc;

        inflight_d = inflight_q + CW'(grant) - CW'(rsp);
        pc_d       = grant ? pc_q + DATA_WIDTH'(4) : pc_q;
        resp_pc_d  = keep ? resp_pc_q + DATA_WIDTH'(4) : resp_pc_q;
        discard_d  = discard_q - CW'(drop);
        count_d    = count_q + CW'(keep) - CW'(pop);
        wr_ptr_d   = keep ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        push_en    = keep;

        if (redirect) begin
            // Everything still outstanding after this cycle (including a
            // grant made right now) belongs to the old path.
            pc_d      = target;
            resp_pc_d = target;
            discard_d = inflight_d;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            push_en   = 1'b0;
        end
`ifdef FETCH_ALIGN_CHK_EN
        err_d = err_q | (redirect && (target_raw[1:0] != 2'b00));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
`ifdef FETCH_ALIGN_CHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
`ifdef FETCH_ALIGN_CHK_EN
            err_q      <= err_d;
`endif
        end
    end

    // Buffer storage needs no reset; count_q alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (push_en) begin
            buf_instr[wr_ptr_q] <= imem_rdata;
            buf_pc[wr_ptr_q]    <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. A small memory model grants every request
// and answers one cycle later with an addi word encoding the request address;
// answers can be held back to keep requests in flight.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic        fetch_err;

    int          n_pass   = 0;
    int          n_checks = 0;
    int          n_grants = 0;
    logic        resp_en;
    logic [31:0] pend[$];

    instr_fetch #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .PCsrc      (PCsrc),
        .ImmOp      (ImmOp),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[11:0], 20'h00013};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Check the request and head outputs for the current cycle.
    task automatic chkc(input string tag, input logic e_req, input logic [31:0] e_addr,
                        input logic e_valid, input logic [31:0] e_pc);
        #1;
        chk({tag, ".req"},   {31'b0, imem_req},    {31'b0, e_req});
        chk({tag, ".addr"},  imem_addr,            e_addr);
        chk({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, e_valid});
        chk({tag, ".instr"}, instr, e_valid ? word_of(e_pc) : 32'h0000_0013);
        if (e_valid) chk({tag, ".pc"}, instr_pc, e_pc);
    endtask

    // Advance one clock; model memory: grant recorded at the edge, oldest
    // pending request answered in the following cycle when resp_en is set.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        logic [31:0] r;
        #1;
        g = imem_req && imem_gnt;
        a = imem_addr;
        @(posedge clk);
        #1;
        if (g) begin
            pend.push_back(a);
            n_grants++;
            $display("[%0t] grant  addr=%h", $time, a);
        end
        if (resp_en && pend.size() > 0) begin
            r           = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(r);
            $display("[%0t] resp   addr=%h data=%h", $time, r, word_of(r));
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b1;
        PCsrc       = 1'b0;
        ImmOp       = 32'h0;
        resp_en     = 1'b1;

        // Reset values
        #2;
        chkc("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        chk("reset.pc0", instr_pc, 32'h0);
        chk("reset.err", {31'b0, fetch_err}, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Streaming with instr_ready held high
        chkc("c0", 1'b1, 32'h00, 1'b0, 32'h00); tick();
        chkc("c1", 1'b1, 32'h04, 1'b0, 32'h00); tick();
        chkc("c2", 1'b0, 32'h08, 1'b1, 32'h00); tick();
        chkc("c3", 1'b1, 32'h08, 1'b1, 32'h04); tick();
        chkc("c4", 1'b1, 32'h0C, 1'b0, 32'h00); tick();
        chkc("c5", 1'b0, 32'h10, 1'b1, 32'h08); tick();
        chkc("c6", 1'b1, 32'h10, 1'b1, 32'h0C); tick();
        chkc("c7", 1'b1, 32'h14, 1'b0, 32'h00); resp_en = 1'b0; tick();

        // Backward branch at 0x10 with the 0x14 response still in flight
        chkc("c8", 1'b0, 32'h18, 1'b1, 32'h10);
        PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8; resp_en = 1'b1; tick();
        // PCsrc while nothing is consumed must be ignored
        ImmOp = 32'h0000_0100;
        chkc("c9",  1'b1, 32'h08, 1'b0, 32'h00); tick();
        chkc("c10", 1'b1, 32'h0C, 1'b0, 32'h00); tick();
        PCsrc = 1'b0;
        chkc("c11", 1'b0, 32'h10, 1'b1, 32'h08); tick();

        // Redirect in the same cycle as a grant of 0x10
        chkc("c12", 1'b1, 32'h10, 1'b1, 32'h0C);
        PCsrc = 1'b1; ImmOp = 32'h0000_0020; tick();
        PCsrc = 1'b0;
        chkc("c13", 1'b1, 32'h2C, 1'b0, 32'h00); tick();
        chkc("c14", 1'b1, 32'h30, 1'b0, 32'h00); tick();
        chkc("c15", 1'b0, 32'h34, 1'b1, 32'h2C); tick();
        chkc("c16", 1'b1, 32'h34, 1'b1, 32'h30); resp_en = 1'b0; tick();

        // Reset with one request (0x34) outstanding; its late response follows
        rst = 1'b1;
        chkc("rst_mid", 1'b0, 32'h00, 1'b0, 32'h00);
        chk("rst_mid.err", {31'b0, fetch_err}, 32'h0);
        resp_en = 1'b1; tick();
        rst = 1'b0;
        chkc("r0", 1'b1, 32'h00, 1'b0, 32'h00); tick();
        chkc("r1", 1'b1, 32'h04, 1'b0, 32'h00); tick();
        chkc("r2", 1'b0, 32'h08, 1'b1, 32'h00);

        // Misaligned redirect target 0x22
        PCsrc = 1'b1; ImmOp = 32'h0000_0022; tick();
        PCsrc = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        chkc("r3", 1'b0, 32'h22, 1'b0, 32'h00);
        chk("r3.err", {31'b0, fetch_err}, 32'h1); tick();
        chkc("r4", 1'b0, 32'h22, 1'b0, 32'h00); tick();
        chkc("r5", 1'b0, 32'h22, 1'b0, 32'h00);
        chk("r5.err", {31'b0, fetch_err}, 32'h1); tick();
`else
        chkc("r3", 1'b1, 32'h20, 1'b0, 32'h00);
        chk("r3.err", {31'b0, fetch_err}, 32'h0); tick();
        chkc("r4", 1'b1, 32'h24, 1'b0, 32'h00); tick();
        chkc("r5", 1'b0, 32'h28, 1'b1, 32'h20); tick();
`endif

        // Fresh start with instr_ready held low for 10 cycles
        rst = 1'b1;
        instr_ready = 1'b0;
        pend.delete();
        imem_rvalid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("hold.err", {31'b0, fetch_err}, 32'h0);
        n_grants = 0;
        PCsrc = 1'b1; ImmOp = 32'h0000_0040;
        for (int i = 0; i < 10; i++) tick();
        chk("hold.grants", n_grants, 32'd2);
        chkc("hold_end", 1'b0, 32'h08, 1'b1, 32'h00);
        PCsrc = 1'b0;
        instr_ready = 1'b1;
        chkc("rel0", 1'b0, 32'h08, 1'b1, 32'h00); tick();
        chkc("rel1", 1'b1, 32'h08, 1'b1, 32'h04); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
